// File: rtl/word_packer.sv
// rtl/word_packer.sv - packs RATIO WIDTH-bit items into one word, with idle-timeout partial emission
// Accumulator feeds a separate output register so a full word can leave while the next one fills.
module word_packer #(
  parameter int WIDTH   = 8,
  parameter int RATIO   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                         i_clk,
  input  logic                         i_rstn,
  input  logic                         i_cg,
  input  logic                         i_flush,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_valid,
  output logic                         o_ready,
  output logic [RATIO*WIDTH-1:0]       o_data,
  output logic [$clog2(RATIO+1)-1:0]   o_count,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic                         o_partial
);

  localparam int CW = $clog2(RATIO + 1);
  localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] FULL_N   = CW'(RATIO);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

  logic [RATIO*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]          acc_n_q, acc_n_d;
  logic [RATIO*WIDTH-1:0] out_data_q, out_data_d;
  logic [CW-1:0]          out_count_q, out_count_d;
  logic                   out_partial_q, out_partial_d;
  logic                   out_valid_q, out_valid_d;
  logic [IW-1:0]          idle_q, idle_d;

  logic full;
  logic timeout_hit;
  logic xfer;
  logic push;
  logic pop;

  assign full        = (acc_n_q == FULL_N);
  assign timeout_hit = (TIMEOUT != 0) && (idle_q == IDLE_MAX) && (acc_n_q != '0);
  assign xfer        = i_cg && !i_flush && (!out_valid_q || i_ready) && (full || timeout_hit);

  assign o_ready   = i_cg && !i_flush && (!full || xfer);
  assign o_valid   = i_cg && out_valid_q;
  assign push      = o_ready && i_valid;
  assign pop       = o_valid && i_ready;

  assign o_data    = out_data_q;
  assign o_count   = out_count_q;
  assign o_partial = out_partial_q;

  always_comb begin
    acc_d         = acc_q;
    acc_n_d       = acc_n_q;
    out_data_d    = out_data_q;
    out_count_d   = out_count_q;
    out_partial_d = out_partial_q;
    out_valid_d   = out_valid_q;
    idle_d        = idle_q;

    if (i_cg) begin
      if (i_flush) begin
        acc_d       = '0;
        acc_n_d     = '0;
        out_valid_d = 1'b0;
      end else if (xfer) begin
        // Lanes at or beyond acc_n are forced to zero so partial words are clean.
        out_data_d = '0;
        for (int k = 0; k < RATIO; k++) begin
          if (CW'(k) < acc_n_q) begin
            out_data_d[k*WIDTH +: WIDTH] = acc_q[k*WIDTH +: WIDTH];
          end
        end
        out_count_d   = acc_n_q;
        out_partial_d = (acc_n_q < FULL_N);
        out_valid_d   = 1'b1;
        acc_d         = '0;
        if (push) begin
          acc_d[WIDTH-1:0] = i_data;
          acc_n_d          = CW'(1);
        end else begin
          acc_n_d = '0;
        end
      end else begin
        if (push) begin
          for (int k = 0; k < RATIO; k++) begin
            if (CW'(k) == acc_n_q) begin
              acc_d[k*WIDTH +: WIDTH] = i_data;
            end
          end
          acc_n_d = acc_n_q + CW'(1);
        end
        if (pop) begin
          out_valid_d = 1'b0;
        end
      end

      // A busy output register leaves idle parked at its limit until xfer can happen.
      if (i_flush || push || xfer || (acc_n_q == '0)) begin
        idle_d = '0;
      end else if (idle_q != IDLE_MAX) begin
        idle_d = idle_q + IW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      acc_q         <= '0;
      acc_n_q       <= '0;
      out_data_q    <= '0;
      out_count_q   <= '0;
      out_partial_q <= 1'b0;
      out_valid_q   <= 1'b0;
      idle_q        <= '0;
    end else begin
      acc_q         <= acc_d;
      acc_n_q       <= acc_n_d;
      out_data_q    <= out_data_d;
      out_count_q   <= out_count_d;
      out_partial_q <= out_partial_d;
      out_valid_q   <= out_valid_d;
      idle_q        <= idle_d;
    end
  end

endmodule

// File: tb/tb_word_packer.sv
// tb/tb_word_packer.sv - directed self-checking bench for word_packer (WIDTH=8, RATIO=4, TIMEOUT=4)
module tb_word_packer;

  logic        i_clk;
  logic        i_rstn;
  logic        i_cg;
  logic        i_flush;
  logic [7:0]  i_data;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] o_data;
  logic [2:0]  o_count;
  logic        o_valid;
  logic        i_ready;
  logic        o_partial;

  int checks   = 0;
  int failures = 0;

  word_packer #(.WIDTH(8), .RATIO(4), .TIMEOUT(4)) dut (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_cg     (i_cg),
    .i_flush  (i_flush),
    .i_data   (i_data),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .o_data   (o_data),
    .o_count  (o_count),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_partial(o_partial)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #2;
  endtask

  initial begin
    logic [31:0] w;
    i_rstn  = 1'b0;
    i_cg    = 1'b1;
    i_flush = 1'b0;
    i_data  = 8'h00;
    i_valid = 1'b0;
    i_ready = 1'b1;
    #3;
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_count", o_count, 3'd0);
    chk("rst_data", o_data, 32'h0);
    chk("rst_partial", o_partial, 1'b0);
    chk("rst_ready", o_ready, 1'b1);
    cyc();
    i_rstn = 1'b1;
    cyc();

    // reset in the middle of a word
    i_valid = 1'b1; i_data = 8'h11; cyc();
    i_data = 8'h22; cyc();
    i_valid = 1'b0;
    i_rstn = 1'b0;
    #1;
    chk("midrst_valid", o_valid, 1'b0);
    chk("midrst_count", o_count, 3'd0);
    #1;
    i_rstn = 1'b1;
    cyc();
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1; i_data = 8'hA0 + 8'(k); cyc();
    end
    i_valid = 1'b0;
    #1;
    chk("a_not_yet", o_valid, 1'b0);
    cyc();
    chk("a_valid", o_valid, 1'b1);
    chk("a_data", o_data, 32'hA3A2A1A0);
    chk("a_count", o_count, 3'd4);
    chk("a_partial", o_partial, 1'b0);
    cyc();
    chk("a_popped", o_valid, 1'b0);

    // full-rate stream
    for (int i = 0; i < 16; i++) begin
      i_valid = 1'b1; i_data = 8'(i);
      #1;
      chk("fr_ready", o_ready, 1'b1);
      chk("fr_valid", o_valid, (i >= 5) && ((i % 4) == 1));
      if ((i >= 5) && ((i % 4) == 1)) begin
        w = {8'(i - 2), 8'(i - 3), 8'(i - 4), 8'(i - 5)};
        chk("fr_data", o_data, w);
      end
      cyc();
    end
    i_valid = 1'b0;
    #1;
    chk("fr_last_wait", o_valid, 1'b0);
    cyc();
    chk("fr_last_valid", o_valid, 1'b1);
    chk("fr_last_data", o_data, 32'h0F0E0D0C);
    cyc();
    chk("fr_idle", o_valid, 1'b0);

    // backpressure
    i_ready = 1'b0;
    for (int j = 0; j < 8; j++) begin
      i_valid = 1'b1; i_data = 8'h10 + 8'(j);
      #1;
      chk("bp_ready", o_ready, 1'b1);
      cyc();
    end
    i_data = 8'h18;
    #1;
    chk("bp_stall_ready", o_ready, 1'b0);
    chk("bp_stall_valid", o_valid, 1'b1);
    chk("bp_stall_data", o_data, 32'h13121110);
    cyc();
    chk("bp_hold_ready", o_ready, 1'b0);
    chk("bp_hold_data", o_data, 32'h13121110);
    i_ready = 1'b1;
    #1;
    chk("bp_release_ready", o_ready, 1'b1);
    cyc();
    i_valid = 1'b0;
    chk("bp_w2_valid", o_valid, 1'b1);
    chk("bp_w2_data", o_data, 32'h17161514);
    chk("bp_w2_count", o_count, 3'd4);
    for (int j = 0; j < 4; j++) begin
      cyc();
      chk("bp_tail_wait", o_valid, 1'b0);
    end
    cyc();
    chk("bp_tail_valid", o_valid, 1'b1);
    chk("bp_tail_data", o_data, 32'h00000018);
    chk("bp_tail_count", o_count, 3'd1);
    chk("bp_tail_partial", o_partial, 1'b1);
    cyc();

    // idle timeout
    i_valid = 1'b1; i_data = 8'h55; cyc();
    i_data = 8'h66; cyc();
    i_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      cyc();
      chk("to_wait", o_valid, 1'b0);
    end
    cyc();
    chk("to_valid", o_valid, 1'b1);
    chk("to_data", o_data, 32'h00006655);
    chk("to_count", o_count, 3'd2);
    chk("to_partial", o_partial, 1'b1);
    cyc();
    chk("to_popped", o_valid, 1'b0);

    // flush with a word pending and a partial accumulator
    i_ready = 1'b0;
    for (int j = 0; j < 7; j++) begin
      i_valid = 1'b1;
      i_data  = (j < 4) ? 8'h30 + 8'(j) : 8'(j - 3);
      cyc();
    end
    i_valid = 1'b0;
    chk("fl_pending_valid", o_valid, 1'b1);
    chk("fl_pending_data", o_data, 32'h33323130);
    i_flush = 1'b1;
    i_valid = 1'b1; i_data = 8'hEE;
    #1;
    chk("fl_ready", o_ready, 1'b0);
    chk("fl_valid_during", o_valid, 1'b1);
    cyc();
    i_flush = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    #1;
    chk("fl_valid_after", o_valid, 1'b0);
    chk("fl_ready_after", o_ready, 1'b1);
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1; i_data = 8'hC0 + 8'(k); cyc();
    end
    i_valid = 1'b0;
    cyc();
    chk("fl_c_valid", o_valid, 1'b1);
    chk("fl_c_data", o_data, 32'hC3C2C1C0);
    chk("fl_c_count", o_count, 3'd4);
    for (int j = 0; j < 7; j++) begin
      cyc();
      chk("fl_no_extra", o_valid, 1'b0);
    end

    // clock-gate pause mid-stream
    for (int k = 0; k < 5; k++) begin
      i_valid = 1'b1; i_data = 8'h40 + 8'(k); cyc();
    end
    i_cg = 1'b0;
    i_data = 8'h45;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("cg_ready", o_ready, 1'b0);
      chk("cg_valid", o_valid, 1'b0);
      cyc();
    end
    i_cg = 1'b1;
    #1;
    chk("cg_resume_valid", o_valid, 1'b1);
    chk("cg_resume_data", o_data, 32'h43424140);
    chk("cg_resume_ready", o_ready, 1'b1);
    cyc();
    i_data = 8'h46; cyc();
    i_data = 8'h47; cyc();
    i_valid = 1'b0;
    #1;
    chk("cg_w2_wait", o_valid, 1'b0);
    cyc();
    chk("cg_w2_valid", o_valid, 1'b1);
    chk("cg_w2_data", o_data, 32'h47464544);
    chk("cg_w2_count", o_count, 3'd4);
    cyc();
    chk("cg_end", o_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
